// File: rtl/csr_access_unit_pkg.sv
// Shared types and constants for the CSR access unit.
// Defines the Zicsr operation encoding, the FSM states and the read-only CSR space marker.
package csr_access_unit_pkg;

  typedef enum logic [2:0] {
    CSR_OP_RW  = 3'b001,
    CSR_OP_RS  = 3'b010,
    CSR_OP_RC  = 3'b011,
    CSR_OP_RWI = 3'b101,
    CSR_OP_RSI = 3'b110,
    CSR_OP_RCI = 3'b111
  } csr_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_acc_state_t;

  localparam logic [1:0] CSR_RO_BITS = 2'b11;

endpackage

// File: rtl/csr_access_unit_if.sv
// Bundle of the execute request, writeback response and CSR file port signals.
// The unit uses the slave modport; the surrounding pipeline/CSR file uses master.
interface csr_access_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [2:0]            req_funct3_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_rs1_data_i;
  logic                  req_rs1_zero_i;
  logic [4:0]            req_zimm_i;
  logic                  req_rd_zero_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [DATA_WIDTH-1:0] resp_data_o;
  logic                  resp_illegal_o;
  logic [ADDR_WIDTH-1:0] csr_rs_o;
  logic [DATA_WIDTH-1:0] csr_rdata_i;
  logic [ADDR_WIDTH-1:0] csr_rd_o;
  logic [DATA_WIDTH-1:0] csr_wdata_o;
  logic                  csr_we_o;

  modport slave (
    input  req_valid_i, req_funct3_i, req_addr_i, req_rs1_data_i, req_rs1_zero_i,
           req_zimm_i, req_rd_zero_i, resp_ready_i, csr_rdata_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_illegal_o,
           csr_rs_o, csr_rd_o, csr_wdata_o, csr_we_o
  );

  modport master (
    output req_valid_i, req_funct3_i, req_addr_i, req_rs1_data_i, req_rs1_zero_i,
           req_zimm_i, req_rd_zero_i, resp_ready_i, csr_rdata_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_illegal_o,
           csr_rs_o, csr_rd_o, csr_wdata_o, csr_we_o
  );
endinterface

// File: rtl/csr_access_unit_csr_alu.sv
// Combinational Zicsr read-modify-write datapath: new value, write decision, legality.
// Only the top two address bits matter for legality, so only those are supplied.
module csr_alu
  import csr_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  csr_op_t               op,
  input  logic [DATA_WIDTH-1:0] old,
  input  logic [DATA_WIDTH-1:0] src,
  input  logic                  rs1_zero,
  input  logic [1:0]            addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  do_write,
  output logic                  illegal
);

  logic bad_op;

  // Per-op new value and write decision; unlisted funct3 codes are illegal
  always_comb begin
    wdata    = old;
    do_write = 1'b0;
    bad_op   = 1'b0;
    case (op)
      CSR_OP_RW, CSR_OP_RWI: begin
        wdata    = src;
        do_write = 1'b1;
      end
      CSR_OP_RS, CSR_OP_RSI: begin
        wdata    = old | src;
        do_write = ~rs1_zero;
      end
      CSR_OP_RC, CSR_OP_RCI: begin
        wdata    = old & ~src;
        do_write = ~rs1_zero;
      end
      default: begin
        wdata    = old;
        do_write = 1'b0;
        bad_op   = 1'b1;
      end
    endcase
    illegal = bad_op | (do_write & (addr == CSR_RO_BITS));
  end

endmodule

// File: rtl/csr_access_unit.sv
// Initiator for the CSR register file: one Zicsr op at a time through IDLE/READ/WRITE/RESP.
// All outputs are registered; the ALU sees the live read data during READ.
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  csr_access_unit_if.slave  bus
);

  csr_acc_state_t        state_r;
  csr_op_t               op_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] src_r;
  logic [DATA_WIDTH-1:0] old_r;
  logic                  rs1_zero_r;
  logic                  rd_zero_r;
  logic                  illegal_r;

  logic [DATA_WIDTH-1:0] src_s;
  logic                  rs1_zero_s;
  logic [DATA_WIDTH-1:0] alu_wdata_s;
  logic                  alu_do_write_s;
  logic                  alu_illegal_s;

  // Immediate variants take a zero-extended zimm and treat zimm==0 as "no source"
  always_comb begin
    src_s      = bus.req_rs1_data_i;
    rs1_zero_s = bus.req_rs1_zero_i;
    if (bus.req_funct3_i[2]) begin
      src_s      = {{(DATA_WIDTH-5){1'b0}}, bus.req_zimm_i};
      rs1_zero_s = (bus.req_zimm_i == 5'd0);
    end else begin
      src_s      = bus.req_rs1_data_i;
      rs1_zero_s = bus.req_rs1_zero_i;
    end
  end

  csr_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .op       (op_r),
    .old      (bus.csr_rdata_i),
    .src      (src_r),
    .rs1_zero (rs1_zero_r),
    .addr     (addr_r[ADDR_WIDTH-1 -: 2]),
    .wdata    (alu_wdata_s),
    .do_write (alu_do_write_s),
    .illegal  (alu_illegal_s)
  );

  // Operation sequencer and registered outputs
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r            <= ST_IDLE;
      op_r               <= CSR_OP_RW;
      addr_r             <= '0;
      src_r              <= '0;
      old_r              <= '0;
      rs1_zero_r         <= 1'b0;
      rd_zero_r          <= 1'b0;
      illegal_r          <= 1'b0;
      bus.req_ready_o    <= 1'b1;
      bus.resp_valid_o   <= 1'b0;
      bus.resp_data_o    <= '0;
      bus.resp_illegal_o <= 1'b0;
      bus.csr_rs_o       <= '0;
      bus.csr_rd_o       <= '0;
      bus.csr_wdata_o    <= '0;
      bus.csr_we_o       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            op_r            <= csr_op_t'(bus.req_funct3_i);
            addr_r          <= bus.req_addr_i;
            src_r           <= src_s;
            rs1_zero_r      <= rs1_zero_s;
            rd_zero_r       <= bus.req_rd_zero_i;
            bus.csr_rs_o    <= bus.req_addr_i;
            bus.req_ready_o <= 1'b0;
            state_r         <= ST_READ;
          end else begin
            bus.req_ready_o <= 1'b1;
          end
        end
        ST_READ: begin
          old_r           <= bus.csr_rdata_i;
          illegal_r       <= alu_illegal_s;
          bus.csr_rd_o    <= addr_r;
          bus.csr_wdata_o <= alu_wdata_s;
          bus.csr_we_o    <= alu_do_write_s & ~alu_illegal_s;
          state_r         <= ST_WRITE;
        end
        ST_WRITE: begin
          bus.csr_we_o       <= 1'b0;
          bus.resp_valid_o   <= 1'b1;
          bus.resp_data_o    <= (rd_zero_r | illegal_r) ? {DATA_WIDTH{1'b0}} : old_r;
          bus.resp_illegal_o <= illegal_r;
          state_r            <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready_i) begin
            bus.resp_valid_o <= 1'b0;
            bus.req_ready_o  <= 1'b1;
            state_r          <= ST_IDLE;
          end else begin
            bus.resp_valid_o <= 1'b1;
          end
        end
        default: begin
          bus.csr_we_o     <= 1'b0;
          bus.resp_valid_o <= 1'b0;
          bus.req_ready_o  <= 1'b1;
          state_r          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: directed scenarios plus randomized ops against a rule-level model.
module tb_csr_access_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  csr_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();

  csr_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file stand-in: the addressed CSR returns cur_old, any other address returns a tagged pattern
  logic [11:0] cur_addr;
  logic [31:0] cur_old;
  assign bus.csr_rdata_i = (bus.csr_rs_o == cur_addr) ? cur_old : (32'hBAD0_0000 | {20'h00000, bus.csr_rs_o});

  int          obs_wait, obs_lat, obs_we_cnt, obs_we_cycle, obs_busy_ready, obs_unstable;
  logic [11:0] obs_we_addr;
  logic [31:0] obs_we_data, obs_data;
  logic        obs_ill, obs_post_valid, obs_post_ready;

  // Reference: Zicsr semantics straight from the architectural rules
  function automatic void model(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                                input logic rs1z, input logic [4:0] zimm, input logic rdz, input logic [31:0] old,
                                output logic ill, output logic we, output logic [31:0] wdata, output logic [31:0] resp);
    logic [31:0] src;
    logic        has_src, writes, bad;
    src     = f3[2] ? {27'd0, zimm} : rs1;
    has_src = f3[2] ? (zimm != 5'd0) : !rs1z;
    bad     = (f3[1:0] == 2'b00);
    writes  = (f3[1:0] == 2'b01) || (!bad && has_src);
    if (f3[1:0] == 2'b01)      wdata = src;
    else if (f3[1:0] == 2'b10) wdata = old | src;
    else                       wdata = old & ~src;
    ill  = bad || (writes && addr[11:10] == 2'b11);
    we   = writes && !ill;
    resp = (ill || rdz) ? 32'd0 : old;
  endfunction

  // Drive one request, record what the DUT did; hold = cycles of response backpressure
  task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1, input logic rs1z,
                       input logic [4:0] zimm, input logic rdz, input logic [31:0] old, input int hold);
    cur_addr = addr;
    cur_old  = old;
    bus.resp_ready_i = (hold == 0);
    obs_wait = 0;
    while (bus.req_ready_o !== 1'b1 && obs_wait < 20) begin
      @(negedge clk);
      obs_wait++;
    end
    bus.req_funct3_i   = f3;
    bus.req_addr_i     = addr;
    bus.req_rs1_data_i = rs1;
    bus.req_rs1_zero_i = rs1z;
    bus.req_zimm_i     = zimm;
    bus.req_rd_zero_i  = rdz;
    bus.req_valid_i    = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid_i    = 1'b0;
    bus.req_addr_i     = 12'($urandom);
    bus.req_rs1_data_i = $urandom;
    bus.req_zimm_i     = 5'($urandom);
    bus.req_funct3_i   = 3'($urandom);
    obs_we_cnt = 0; obs_lat = 0; obs_busy_ready = 0; obs_unstable = 0; obs_we_cycle = 0;
    obs_we_addr = 12'd0; obs_we_data = 32'd0; obs_data = 32'd0; obs_ill = 1'b0;
    for (int c = 1; c <= 20 && obs_lat == 0; c++) begin
      @(negedge clk);
      if (bus.req_ready_o) obs_busy_ready++;
      if (bus.csr_we_o) begin
        obs_we_cnt++;
        obs_we_addr  = bus.csr_rd_o;
        obs_we_data  = bus.csr_wdata_o;
        obs_we_cycle = c;
      end
      if (bus.resp_valid_o) begin
        obs_lat  = c;
        obs_data = bus.resp_data_o;
        obs_ill  = bus.resp_illegal_o;
      end
    end
    for (int h = 0; h < hold && obs_lat != 0; h++) begin
      @(negedge clk);
      if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== obs_data || bus.resp_illegal_o !== obs_ill ||
          bus.req_ready_o !== 1'b0 || bus.csr_we_o !== 1'b0) obs_unstable++;
    end
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    obs_post_valid = bus.resp_valid_o;
    obs_post_ready = bus.req_ready_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_funct3_i = 3'd0; bus.req_addr_i = 12'd0; bus.req_rs1_data_i = 32'd0;
    bus.req_rs1_zero_i = 1'b0; bus.req_zimm_i = 5'd0; bus.req_rd_zero_i = 1'b0; bus.resp_ready_i = 1'b1;
    cur_addr = 12'd0; cur_old = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready_o); end
    checks++; if (bus.resp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid_o); end
    checks++; if (bus.csr_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.csr_we_o); end
    checks++; if (bus.resp_data_o !== 32'd0 || bus.resp_illegal_o !== 1'b0) begin
      failures++; $display("FAIL reset_resp got=%h/%b exp=0/0", bus.resp_data_o, bus.resp_illegal_o); end
    checks++; if (bus.csr_rs_o !== 12'd0 || bus.csr_rd_o !== 12'd0 || bus.csr_wdata_o !== 32'd0) begin
      failures++; $display("FAIL reset_csr_port got=%h/%h/%h exp=0/0/0", bus.csr_rs_o, bus.csr_rd_o, bus.csr_wdata_o); end
  endtask

  task automatic test_ro_read();
    issue(3'b010, 12'hC00, 32'd0, 1'b1, 5'd0, 1'b0, 32'h0000_0123, 0);
    checks++; if (obs_lat != 3) begin failures++; $display("FAIL ro_latency got=%0d exp=3", obs_lat); end
    checks++; if (obs_we_cnt != 0) begin failures++; $display("FAIL ro_no_write got=%0d exp=0", obs_we_cnt); end
    checks++; if (obs_data !== 32'h0000_0123) begin failures++; $display("FAIL ro_data got=%h exp=00000123", obs_data); end
    checks++; if (obs_ill !== 1'b0) begin failures++; $display("FAIL ro_illegal got=%b exp=0", obs_ill); end
  endtask

  task automatic test_rw();
    issue(3'b001, 12'h340, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 32'h1234_5678, 0);
    checks++; if (obs_we_cnt != 1 || obs_we_cycle != 2) begin
      failures++; $display("FAIL rw_we_pulse got=%0d@%0d exp=1@2", obs_we_cnt, obs_we_cycle); end
    checks++; if (obs_we_addr !== 12'h340) begin failures++; $display("FAIL rw_wr_addr got=%h exp=340", obs_we_addr); end
    checks++; if (obs_we_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rw_wdata got=%h exp=deadbeef", obs_we_data); end
    checks++; if (obs_data !== 32'h1234_5678) begin failures++; $display("FAIL rw_resp got=%h exp=12345678", obs_data); end
  endtask

  task automatic test_set_clear();
    issue(3'b011, 12'h300, 32'h0000_00F0, 1'b0, 5'd0, 1'b0, 32'h0000_00FF, 0);
    checks++; if (obs_we_cnt != 1 || obs_we_data !== 32'h0000_000F) begin
      failures++; $display("FAIL rc_wdata got=%0d/%h exp=1/0000000f", obs_we_cnt, obs_we_data); end
    issue(3'b110, 12'h300, 32'd0, 1'b0, 5'd5, 1'b0, 32'h0000_00FF, 0);
    checks++; if (obs_we_cnt != 1 || obs_we_data !== 32'h0000_00FF) begin
      failures++; $display("FAIL rsi_wdata got=%0d/%h exp=1/000000ff", obs_we_cnt, obs_we_data); end
    issue(3'b110, 12'h300, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0, 32'h0000_00FF, 0);
    checks++; if (obs_we_cnt != 0) begin failures++; $display("FAIL rsi_zero_nowrite got=%0d exp=0", obs_we_cnt); end
    checks++; if (obs_data !== 32'h0000_00FF) begin failures++; $display("FAIL rsi_zero_resp got=%h exp=000000ff", obs_data); end
  endtask

  task automatic test_illegal();
    issue(3'b101, 12'hC01, 32'd0, 1'b0, 5'd3, 1'b0, 32'h7777_7777, 0);
    checks++; if (obs_ill !== 1'b1 || obs_data !== 32'd0) begin
      failures++; $display("FAIL ill_ro_write got=%b/%h exp=1/00000000", obs_ill, obs_data); end
    checks++; if (obs_we_cnt != 0 || obs_lat != 3) begin
      failures++; $display("FAIL ill_ro_we got=%0d lat=%0d exp=0 lat=3", obs_we_cnt, obs_lat); end
    issue(3'b100, 12'h300, 32'h1111_1111, 1'b0, 5'd7, 1'b0, 32'h8888_8888, 0);
    checks++; if (obs_ill !== 1'b1 || obs_data !== 32'd0 || obs_we_cnt != 0) begin
      failures++; $display("FAIL ill_funct3 got=%b/%h/%0d exp=1/00000000/0", obs_ill, obs_data, obs_we_cnt); end
  endtask

  task automatic test_back_to_back();
    issue(3'b010, 12'h305, 32'h0000_0F00, 1'b0, 5'd0, 1'b0, 32'hA5A5_0000, 5);
    checks++; if (obs_unstable != 0) begin failures++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", obs_unstable); end
    checks++; if (obs_data !== 32'hA5A5_0000 || obs_busy_ready != 0) begin
      failures++; $display("FAIL bp_resp got=%h ready_hi=%0d exp=a5a50000 0", obs_data, obs_busy_ready); end
    checks++; if (obs_post_valid !== 1'b0 || obs_post_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got=v%b r%b exp=v0 r1", obs_post_valid, obs_post_ready); end
    issue(3'b001, 12'h341, 32'h0000_1000, 1'b0, 5'd0, 1'b1, 32'h5555_AAAA, 0);
    checks++; if (obs_wait != 0 || obs_lat != 3) begin
      failures++; $display("FAIL b2b_accept got=wait%0d lat%0d exp=wait0 lat3", obs_wait, obs_lat); end
    checks++; if (obs_data !== 32'd0 || obs_we_data !== 32'h0000_1000) begin
      failures++; $display("FAIL b2b_rdzero got=%h/%h exp=00000000/00001000", obs_data, obs_we_data); end
  endtask

  task automatic test_reset_mid();
    int late_we;
    cur_addr = 12'h340; cur_old = 32'h0BAD_F00D;
    bus.resp_ready_i = 1'b1;
    bus.req_funct3_i = 3'b001; bus.req_addr_i = 12'h340; bus.req_rs1_data_i = 32'h0000_0055;
    bus.req_rs1_zero_i = 1'b0; bus.req_rd_zero_i = 1'b0; bus.req_valid_i = 1'b1;
    @(posedge clk); #1; bus.req_valid_i = 1'b0;
    @(posedge clk); #2;
    checks++; if (bus.csr_we_o !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_we got=%b exp=1", bus.csr_we_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.csr_we_o !== 1'b0 || bus.resp_valid_o !== 1'b0) begin
      failures++; $display("FAIL rst_mid_async got=we%b v%b exp=we0 v0", bus.csr_we_o, bus.resp_valid_o); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    late_we = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.csr_we_o || bus.resp_valid_o || !bus.req_ready_o) late_we++;
    end
    checks++; if (late_we != 0) begin failures++; $display("FAIL rst_mid_after got=%0d bad cycles exp=0", late_we); end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] rs1, old, e_wdata, e_resp;
    logic        rs1z, rdz, e_ill, e_we;
    logic [4:0]  zimm;
    int          hold;
    for (int i = 0; i < 40; i++) begin
      f3   = 3'($urandom_range(0, 7));
      addr = 12'($urandom);
      if ($urandom_range(0, 3) == 0) addr[11:10] = 2'b11;
      rs1z = ($urandom_range(0, 3) == 0);
      rs1  = rs1z ? 32'd0 : $urandom;
      zimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rdz  = ($urandom_range(0, 3) == 0);
      old  = $urandom;
      hold = $urandom_range(0, 2);
      model(f3, addr, rs1, rs1z, zimm, rdz, old, e_ill, e_we, e_wdata, e_resp);
      issue(f3, addr, rs1, rs1z, zimm, rdz, old, hold);
      checks++; if (obs_lat != 3) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=3", i, obs_lat); end
      checks++; if (obs_we_cnt != (e_we ? 1 : 0)) begin
        failures++; $display("FAIL rnd%0d_we_count f3=%b got=%0d exp=%0d", i, f3, obs_we_cnt, e_we ? 1 : 0); end
      if (e_we) begin
        checks++; if (obs_we_addr !== addr || obs_we_data !== e_wdata || obs_we_cycle != 2) begin
          failures++; $display("FAIL rnd%0d_write got=%h:%h@%0d exp=%h:%h@2", i, obs_we_addr, obs_we_data, obs_we_cycle, addr, e_wdata); end
      end
      checks++; if (obs_data !== e_resp || obs_ill !== e_ill) begin
        failures++; $display("FAIL rnd%0d_resp f3=%b got=%h/%b exp=%h/%b", i, f3, obs_data, obs_ill, e_resp, e_ill); end
      checks++; if (obs_busy_ready != 0 || obs_unstable != 0 || obs_post_valid !== 1'b0 || obs_post_ready !== 1'b1) begin
        failures++; $display("FAIL rnd%0d_handshake got=busy%0d unst%0d v%b r%b exp=0 0 0 1", i, obs_busy_ready, obs_unstable, obs_post_valid, obs_post_ready); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_ro_read();
    test_rw();
    test_set_clear();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the CSR register-file interface.
- Accepts one decoded Zicsr instruction from execute over a valid/ready handshake.
- Performs the read-modify-write sequence on the CSR file's read port (rs/out) and write port (rd/in/we).
- Returns the old CSR value, or an illegal-instruction flag, to writeback over a second valid/ready handshake.
- At most one operation is in flight.

Parameters:
DATA_WIDTH, 32, CSR data width and rs1/result width
ADDR_WIDTH, 12, CSR address width

Ports:
clk_i  in  1  clock; all state updates on the rising edge
reset_ni  in  1  asynchronous, active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  unit can accept a request
req_funct3_i  in  3  Zicsr funct3 (csr_op_t)
req_addr_i  in  ADDR_WIDTH  target CSR address
req_rs1_data_i  in  DATA_WIDTH  rs1 register value
req_rs1_zero_i  in  1  rs1 field == x0
req_zimm_i  in  5  immediate for the I variants
req_rd_zero_i  in  1  rd field == x0
resp_valid_o  out  1  response valid
resp_ready_i  in  1  writeback accepts the response
resp_data_o  out  DATA_WIDTH  old CSR value (0 if rd==x0 or illegal)
resp_illegal_o  out  1  illegal-instruction flag
csr_rs_o  out  ADDR_WIDTH  CSR read address
csr_rdata_i  in  DATA_WIDTH  CSR read data (combinational from csr_rs_o)
csr_rd_o  out  ADDR_WIDTH  CSR write address
csr_wdata_o  out  DATA_WIDTH  CSR write data
csr_we_o  out  1  CSR write enable

Behaviour:
- Reset (async assert, any state):
  - FSM goes to IDLE.
  - resp_valid_o=0, csr_we_o=0, resp_illegal_o=0, resp_data_o=0, csr_rs_o=0, csr_rd_o=0, csr_wdata_o=0.
  - req_ready_o=1 once in IDLE.
  - An in-flight operation is discarded and no write is issued.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE: req_ready_o=1. On req_valid_i: latch funct3, addr, src, rs1_zero, rd_zero, then go to READ.
  - READ: csr_rs_o=latched addr. Register old=csr_rdata_i at the clock edge, then go to WRITE.
  - WRITE: csr_rd_o=addr, csr_wdata_o=computed value, csr_we_o=do_write. Go to RESP.
  - RESP: resp_valid_o=1. Hold until resp_ready_i=1, then go to IDLE.
- req_ready_o=0 outside IDLE.
- Latency: the accept edge is E0. READ occupies cycle 1, WRITE cycle 2, and resp_valid_o is first high in cycle 3.
- Throughput: 1 operation per 4 cycles with resp_ready_i tied high.
- csr_we_o is high for exactly one cycle per legal writing operation and never in any other state.
- src operand:
  - funct3[2]=0: src=req_rs1_data_i.
  - funct3[2]=1: src=zero-extended req_zimm_i; in this case rs1_zero is (zimm==0).
- New value:
  - RW/RWI: src.
  - RS/RSI: old|src.
  - RC/RCI: old & ~src.
- do_write:
  - RW/RWI: always.
  - RS/RC variants: only if !rs1_zero.
- illegal is set when either:
  - funct3 is 000 or 100, or
  - do_write and addr[11:10]==2'b11 (read-only space, e.g. cycle/time/instret).
- An illegal operation forces csr_we_o=0 and resp_data_o=0, and still passes through all states.
- resp_data_o = old, except 0 when rd_zero or illegal.
- resp_data_o and resp_illegal_o are stable while resp_valid_o=1 && !resp_ready_i.
- No new request is accepted in the same cycle the response handshakes; the next accept occurs in IDLE.

Decomposition:
- Package definitions:
  - csr_op_t enum: CSR_OP_RW=3'b001, RS=010, RC=011, RWI=101, RSI=110, RCI=111.
  - csr_acc_state_t enum.
  - CSR_RO_BITS=2'b11 constant.
- Sub-module csr_alu, purely combinational.
  - Inputs: op, old, src, rs1_zero, addr.
  - Outputs: wdata, do_write, illegal.
  - Instantiated once.

Test Plan:
1. Read-only CSR read, no write: CSRRS (010), addr 0xC00, rs1=x0, csr_rdata_i=0x0000_0123 in READ -> csr_we_o never asserted; resp_data_o=0x0000_0123, resp_illegal_o=0, resp_valid_o high 3 cycles after accept.
2. CSRRW: addr 0x340, rs1=0xDEADBEEF, old=0x12345678 -> one-cycle csr_we_o with csr_rd_o=0x340, csr_wdata_o=0xDEADBEEF; resp_data_o=0x12345678.
3. Set/clear variants, old=0x0000_00FF:
   - CSRRC, rs1=0x0000_00F0 -> wdata=0x0000_000F.
   - CSRRSI, zimm=5 -> wdata=0x0000_00FF with csr_we_o=1.
   - CSRRSI, zimm=0 -> csr_we_o=0.
4. Illegal requests -> resp_illegal_o=1, resp_data_o=0, csr_we_o=0 throughout:
   - CSRRWI, addr 0xC01, zimm=3.
   - funct3=100.
5. Backpressure then back-to-back: resp_ready_i held low for 5 cycles -> resp_valid_o and resp_data_o stable, req_ready_o=0. Release, then a second request -> accepted the following cycle in IDLE.
6. Reset mid-operation: assert reset_ni=0 asynchronously during WRITE -> csr_we_o drops immediately, no write occurs. After release: req_ready_o=1, resp_valid_o=0.
